alu_op_scheduler: RTL and testbench
===================================

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, max cycles to wait for alu_done_i per issued operation (legal range 2..65535).
REQ-002 SHALL have port: clk_i  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: cmd_valid_i input 1, cmd_ready_o output 1, cmd_opcode_i input 8, cmd_count_i input 8; command from the packet parser (opcode, operand count).
REQ-005 SHALL have ports: op_valid_i input 1, op_ready_o output 1, op_data_i input 32; operand stream.
REQ-006 SHALL have ports: alu_start_o output 1, alu_opcode_o output 8, alu_a_o output 32, alu_b_o output 32, alu_done_i input 1, alu_result_i input 32; shared multi-cycle ALU.
REQ-007 SHALL have ports: tx_data_o output 8, tx_valid_o output 1, tx_ready_i input 1; result bytes to the UART transmitter.
REQ-008 SHALL have ports: busy_o output 1 (state != IDLE), err_o output 1 (one-cycle error pulse).

Function
REQ-009 SHALL implement states IDLE, WAIT_OPND, WAIT_ALU, SEND; all transfers occur on valid&ready in the same cycle.
REQ-010 SHALL support opcodes 0xEC ECHO, 0xA0 ADD32, 0xA1 MUL32, 0xA2 DIV32; alu_opcode_o carries the latched opcode.
REQ-011 cmd_ready_o SHALL be 1 only in IDLE; op_ready_o SHALL be 1 only in WAIT_OPND.
REQ-012 On command accept with supported opcode and count>=1: latch opcode and count, clear operand counter, enter WAIT_OPND next cycle.
REQ-013 On command accept with unsupported opcode or count==0: err_o=1 next cycle for one cycle, remain IDLE, consume no operands, no TX.
REQ-014 First accepted operand SHALL load accumulator directly (no ALU issue).
REQ-015 For ECHO, every accepted operand SHALL overwrite the accumulator; no ALU issue ever.
REQ-016 For ADD32/MUL32/DIV32, each operand after the first SHALL cause alu_start_o=1 for exactly one cycle, the cycle after acceptance, with alu_a_o=accumulator, alu_b_o=operand; state WAIT_ALU.
REQ-017 alu_a_o, alu_b_o, alu_opcode_o SHALL stay stable from start pulse until alu_done_i sampled in WAIT_ALU.
REQ-018 alu_done_i SHALL be ignored outside WAIT_ALU and in the start-pulse cycle.
REQ-019 On alu_done_i in WAIT_ALU: accumulator <= alu_result_i (32-bit, no width growth; wrap/divide-by-zero result is the ALU's); next cycle WAIT_OPND if operands remain, else SEND.
REQ-020 When the last operand is accepted and no ALU issue is needed (count==1 or ECHO), SHALL enter SEND next cycle.
REQ-021 WAIT_ALU timeout counter SHALL clear on entry; if TIMEOUT_CYCLES cycles elapse without alu_done_i: err_o one-cycle pulse, return to IDLE, discard accumulator, no TX; remaining operands are not consumed.
REQ-022 SEND SHALL emit 4 bytes LSB first: byte i = accumulator[8i+7:8i], i=0..3.
REQ-023 tx_valid_o SHALL stay 1 and tx_data_o stable until tx_ready_i; byte index advances only on handshake.
REQ-024 After byte 3 handshake, SHALL enter IDLE next cycle (cmd_ready_o=1).
REQ-025 Operand counter SHALL be 8 bits, no wrap: count 255 processes exactly 255 operands.
REQ-026 alu_start_o SHALL never assert in IDLE, WAIT_OPND or SEND.

Reset
REQ-027 rst_i high at a clock edge SHALL force IDLE, clear accumulator, counters, byte index, timeout counter, from any state including mid-ALU and mid-SEND.
REQ-028 Values while/after reset: cmd_ready_o=1, op_ready_o=0, alu_start_o=0, alu_opcode_o/alu_a_o/alu_b_o=0, tx_valid_o=0, tx_data_o=0x00, busy_o=0, err_o=0.
REQ-029 An alu_done_i arriving after reset SHALL be ignored.

Verification
REQ-030 ADD32, count 3, operands 5, 7, 0xFFFFFFFF, ALU done after 3 cycles -> two start pulses (5,7) then (12,0xFFFFFFFF); TX bytes 0x0B,0x00,0x00,0x00.
REQ-031 MUL32, count 2, operands 0x00010000, 0x00010000 -> one start pulse; ALU returns 0 -> TX 0x00,0x00,0x00,0x00.
REQ-032 ECHO, count 1, operand 0xDEADBEEF -> no alu_start_o; TX 0xEF,0xBE,0xAD,0xDE; tx_ready_i low 10 cycles on byte 1 -> 0xBE held, no skip/duplicate.
REQ-033 Opcode 0x55 count 2 -> err_o one cycle, op_ready_o stays 0, no TX; following valid ECHO accepted normally.
REQ-034 DIV32 count 2, alu_done_i never asserted -> err_o exactly TIMEOUT_CYCLES cycles after start, IDLE, tx_valid_o never 1.
REQ-035 rst_i asserted during SEND byte 2 -> next cycle tx_valid_o=0, cmd_ready_o=1, busy_o=0; next ADD32 count 1 operand 9 -> TX 0x09,0x00,0x00,0x00.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Sequences an operand stream through a shared multi-cycle ALU and returns the
// 32-bit accumulator to a byte-wide UART transmitter, least significant byte first.
module alu_op_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [7:0]  cmd_count_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [31:0] op_data_i,
    output logic        alu_start_o,
    output logic [7:0]  alu_opcode_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic        alu_done_i,
    input  logic [31:0] alu_result_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [7:0]  OP_ECHO  = 8'hEC;
    localparam logic [7:0]  OP_ADD32 = 8'hA0;
    localparam logic [7:0]  OP_MUL32 = 8'hA1;
    localparam logic [7:0]  OP_DIV32 = 8'hA2;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitOpnd,
        StWaitAlu,
        StSend
    } state_e;

    state_e      r_state;
    logic [7:0]  r_opcode;
    logic [7:0]  r_count;
    logic [7:0]  r_opnd_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_alu_start;
    logic [15:0] r_tmo;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_err;

    logic        w_cmd_fire;
    logic        w_op_fire;
    logic        w_tx_fire;
    logic        w_supported;
    logic        w_cmd_ok;
    logic        w_no_alu;
    logic        w_last;
    logic        w_more;
    logic        w_done_ok;
    logic        w_tmo_hit;
    logic [1:0]  w_next_idx;

    assign cmd_ready_o  = (r_state == StIdle);
    assign op_ready_o   = (r_state == StWaitOpnd);
    assign busy_o       = (r_state != StIdle);
    assign alu_start_o  = r_alu_start;
    assign alu_opcode_o = r_opcode;
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign tx_data_o    = r_tx_data;
    assign tx_valid_o   = r_tx_valid;
    assign err_o        = r_err;

    assign w_cmd_fire  = cmd_valid_i & cmd_ready_o;
    assign w_op_fire   = op_valid_i & op_ready_o;
    assign w_tx_fire   = r_tx_valid & tx_ready_i;
    assign w_supported = (cmd_opcode_i == OP_ECHO)  | (cmd_opcode_i == OP_ADD32) |
                         (cmd_opcode_i == OP_MUL32) | (cmd_opcode_i == OP_DIV32);
    assign w_cmd_ok    = w_supported & (cmd_count_i != 8'd0);
    // The first operand seeds the accumulator; ECHO never uses the ALU at all.
    assign w_no_alu    = (r_opnd_cnt == 8'd0) | (r_opcode == OP_ECHO);
    assign w_last      = (r_opnd_cnt == r_count - 8'd1);
    assign w_more      = (r_opnd_cnt != r_count);
    // A done coinciding with the start pulse belongs to no issued operation.
    assign w_done_ok   = alu_done_i & ~r_alu_start;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_next_idx  = r_byte_idx + 2'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_opcode    <= 8'h00;
            r_count     <= 8'h00;
            r_opnd_cnt  <= 8'h00;
            r_acc       <= 32'h0;
            r_alu_a     <= 32'h0;
            r_alu_b     <= 32'h0;
            r_alu_start <= 1'b0;
            r_tmo       <= 16'h0;
            r_byte_idx  <= 2'd0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_err       <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_cmd_fire) begin
                        if (w_cmd_ok) begin
                            r_opcode   <= cmd_opcode_i;
                            r_count    <= cmd_count_i;
                            r_opnd_cnt <= 8'd0;
                            r_state    <= StWaitOpnd;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StWaitOpnd: begin
                    if (w_op_fire) begin
                        r_opnd_cnt <= r_opnd_cnt + 8'd1;
                        if (w_no_alu) begin
                            r_acc <= op_data_i;
                            if (w_last) begin
                                r_state    <= StSend;
                                r_byte_idx <= 2'd0;
                                r_tx_data  <= op_data_i[7:0];
                                r_tx_valid <= 1'b1;
                            end
                        end else begin
                            r_alu_a     <= r_acc;
                            r_alu_b     <= op_data_i;
                            r_alu_start <= 1'b1;
                            r_tmo       <= 16'h0;
                            r_state     <= StWaitAlu;
                        end
                    end
                end
                StWaitAlu: begin
                    if (w_done_ok) begin
                        r_acc <= alu_result_i;
                        if (w_more) begin
                            r_state <= StWaitOpnd;
                        end else begin
                            r_state    <= StSend;
                            r_byte_idx <= 2'd0;
                            r_tx_data  <= alu_result_i[7:0];
                            r_tx_valid <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_acc   <= 32'h0;
                        r_state <= StIdle;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                StSend: begin
                    if (w_tx_fire) begin
                        if (r_byte_idx == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_byte_idx <= 2'd0;
                            r_state    <= StIdle;
                        end else begin
                            r_byte_idx <= w_next_idx;
                            r_tx_data  <= r_acc[{w_next_idx, 3'b000} +: 8];
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: expected ALU issues and TX bytes are queued
// as stimulus is driven and checked by a negedge monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_alu_op_scheduler;

    localparam int unsigned TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_opcode_i;
    logic [7:0]  cmd_count_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [31:0] op_data_i;
    logic        alu_start_o;
    logic [7:0]  alu_opcode_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_done_i;
    logic [31:0] alu_result_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        err_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_tx[$];
    logic [71:0] exp_start[$];
    logic [71:0] mon_e;
    logic [7:0]  mon_b;
    int          alu_delay = 1;
    bit          alu_hang  = 1'b0;

    alu_op_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i), .cmd_count_i(cmd_count_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i),
        .alu_start_o(alu_start_o), .alu_opcode_o(alu_opcode_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            8'hA0:   return a + b;
            8'hA1:   return a * b;
            8'hA2:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'hDEAD_0000;
        endcase
    endfunction

    // Behavioural shared ALU: answers each start pulse after alu_delay cycles.
    initial begin : alu_resp
        logic [31:0] res;
        alu_done_i   = 1'b0;
        alu_result_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (alu_start_o && !alu_hang) begin
                res = alu_model(alu_opcode_o, alu_a_o, alu_b_o);
                repeat (alu_delay) @(posedge clk_i);
                #1;
                alu_done_i   = 1'b1;
                alu_result_i = res;
                @(posedge clk_i);
                #1;
                alu_done_i   = 1'b0;
                alu_result_i = $urandom;
            end
        end
    end

    always @(negedge clk_i) begin
        if (alu_start_o) begin
            n_checks++;
            if (exp_start.size() == 0) begin
                n_fail++;
                $display("FAIL alu_start_unexpected: got op=%h a=%h b=%h, required no start",
                         alu_opcode_o, alu_a_o, alu_b_o);
            end else begin
                mon_e = exp_start.pop_front();
                if ({alu_opcode_o, alu_a_o, alu_b_o} !== mon_e) begin
                    n_fail++;
                    $display("FAIL alu_start_operands: got %h/%h/%h, required %h/%h/%h",
                             alu_opcode_o, alu_a_o, alu_b_o, mon_e[71:64], mon_e[63:32],
                             mon_e[31:0]);
                end
            end
            n_checks++;
            if ({cmd_ready_o, op_ready_o, tx_valid_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL alu_start_state: got cmd_rdy/op_rdy/tx_vld=%b, required 000",
                         {cmd_ready_o, op_ready_o, tx_valid_o});
            end
        end
        if (tx_valid_o && tx_ready_i) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got byte %h, required no transfer", tx_data_o);
            end else begin
                mon_b = exp_tx.pop_front();
                if (tx_data_o !== mon_b) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h, required %h", tx_data_o, mon_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] cnt);
        int k = 0;
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        cmd_count_i  = cnt;
        while (!cmd_ready_o && k < 300) begin tick(); k++; end
        n_checks++;
        if (!cmd_ready_o) begin
            n_fail++;
            $display("FAIL cmd_handshake: cmd_ready_o got %b after %0d cycles, required 1",
                     cmd_ready_o, k);
        end
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_opnd(input logic [31:0] d);
        int k = 0;
        op_valid_i = 1'b1;
        op_data_i  = d;
        while (!op_ready_o && k < 300) begin tick(); k++; end
        n_checks++;
        if (!op_ready_o) begin
            n_fail++;
            $display("FAIL op_handshake: op_ready_o got %b after %0d cycles, required 1",
                     op_ready_o, k);
        end
        tick();
        op_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy_o && k < budget) begin tick(); k++; end
        n_checks++;
        if (busy_o) begin
            n_fail++;
            $display("FAIL %s_idle: busy_o got %b after %0d cycles, required 0",
                     name, busy_o, budget);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({cmd_ready_o, op_ready_o, alu_start_o, busy_o, err_o, tx_valid_o} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 100000",
                     {cmd_ready_o, op_ready_o, alu_start_o, busy_o, err_o, tx_valid_o});
        end
        n_checks++;
        if ({alu_opcode_o, alu_a_o, alu_b_o, tx_data_o} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h, required all zero",
                     alu_opcode_o, alu_a_o, alu_b_o, tx_data_o);
        end
        rst_i = 1'b0;
        tick();
        n_checks++;
        if ({cmd_ready_o, busy_o, err_o, tx_valid_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: got %b, required 1000",
                     {cmd_ready_o, busy_o, err_o, tx_valid_o});
        end
    endtask

    task automatic test_add();
        alu_delay = 3;
        exp_start.push_back({8'hA0, 32'd5, 32'd7});
        exp_start.push_back({8'hA0, 32'd12, 32'hFFFF_FFFF});
        exp_tx.push_back(8'h0B); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        send_cmd(8'hA0, 8'd3);
        send_opnd(32'd5);
        send_opnd(32'd7);
        for (int i = 0; i < 20 && !op_ready_o; i++) begin
            n_checks++;
            if ({alu_opcode_o, alu_a_o, alu_b_o} !== {8'hA0, 32'd5, 32'd7}) begin
                n_fail++;
                $display("FAIL add_alu_hold: got %h/%h/%h, required a0/00000005/00000007",
                         alu_opcode_o, alu_a_o, alu_b_o);
            end
            tick();
        end
        send_opnd(32'hFFFF_FFFF);
        wait_idle("add", 50);
        n_checks++;
        if (exp_tx.size() != 0 || exp_start.size() != 0) begin
            n_fail++;
            $display("FAIL add_drain: got %0d tx/%0d starts left, required 0/0",
                     exp_tx.size(), exp_start.size());
        end
    endtask

    task automatic test_mul();
        alu_delay = 2;
        exp_start.push_back({8'hA1, 32'h0001_0000, 32'h0001_0000});
        repeat (4) exp_tx.push_back(8'h00);
        send_cmd(8'hA1, 8'd2);
        send_opnd(32'h0001_0000);
        send_opnd(32'h0001_0000);
        wait_idle("mul", 50);
        n_checks++;
        if (exp_tx.size() != 0 || exp_start.size() != 0) begin
            n_fail++;
            $display("FAIL mul_drain: got %0d tx/%0d starts left, required 0/0",
                     exp_tx.size(), exp_start.size());
        end
    endtask

    task automatic test_echo_stall();
        tx_ready_i = 1'b0;
        exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
        send_cmd(8'hEC, 8'd1);
        send_opnd(32'hDEAD_BEEF);
        n_checks++;
        if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hEF}) begin
            n_fail++;
            $display("FAIL echo_first_byte: got vld=%b data=%h, required 1/ef",
                     tx_valid_o, tx_data_o);
        end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hBE}) begin
                n_fail++;
                $display("FAIL echo_stall_hold: cycle %0d got vld=%b data=%h, required 1/be",
                         i, tx_valid_o, tx_data_o);
            end
            tick();
        end
        tx_ready_i = 1'b1;
        wait_idle("echo", 20);
        n_checks++;
        if (exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL echo_drain: got %0d tx left, required 0", exp_tx.size());
        end
    endtask

    task automatic test_bad_opcode();
        send_cmd(8'h55, 8'd2);
        n_checks++;
        if ({err_o, cmd_ready_o, op_ready_o, busy_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL bad_op_err: got err/cmd_rdy/op_rdy/busy=%b, required 1100",
                     {err_o, cmd_ready_o, op_ready_o, busy_o});
        end
        op_valid_i = 1'b1;
        op_data_i  = 32'h1234_5678;
        tick();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_op_err_width: got err_o=%b, required 0", err_o);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (op_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_op_no_opnd: got op_ready_o=%b, required 0", op_ready_o);
            end
            tick();
        end
        op_valid_i = 1'b0;
        send_cmd(8'hA0, 8'd0);
        n_checks++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_count_err: got err/busy=%b, required 10", {err_o, busy_o});
        end
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        send_cmd(8'hEC, 8'd1);
        send_opnd(32'hCAFE_F00D);
        wait_idle("bad_op_echo", 20);
        n_checks++;
        if (exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL bad_op_drain: got %0d tx left, required 0", exp_tx.size());
        end
    endtask

    task automatic test_timeout();
        alu_hang = 1'b1;
        exp_start.push_back({8'hA2, 32'd100, 32'd7});
        send_cmd(8'hA2, 8'd2);
        send_opnd(32'd100);
        send_opnd(32'd7);
        n_checks++;
        if (alu_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_start: got alu_start_o=%b, required 1", alu_start_o);
        end
        for (int i = 1; i <= int'(TMO); i++) begin
            tick();
            n_checks++;
            if (i < int'(TMO)) begin
                if ({err_o, busy_o} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL tmo_wait: cycle %0d got err/busy=%b, required 01",
                             i, {err_o, busy_o});
                end
            end else if ({err_o, busy_o, cmd_ready_o, tx_valid_o} !== 4'b1010) begin
                n_fail++;
                $display("FAIL tmo_fire: got err/busy/cmd_rdy/tx_vld=%b, required 1010",
                         {err_o, busy_o, cmd_ready_o, tx_valid_o});
            end
        end
        tick();
        n_checks++;
        if ({err_o, tx_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_after: got err/tx_vld=%b, required 00", {err_o, tx_valid_o});
        end
        alu_hang = 1'b0;
    endtask

    task automatic test_reset_mid_alu();
        alu_delay = 4;
        exp_start.push_back({8'hA0, 32'd1, 32'd2});
        send_cmd(8'hA0, 8'd2);
        send_opnd(32'd1);
        send_opnd(32'd2);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({busy_o, tx_valid_o, cmd_ready_o, err_o} !== 4'b0010) begin
                n_fail++;
                $display("FAIL rst_alu_ignore_done: cycle %0d got %b, required 0010",
                         i, {busy_o, tx_valid_o, cmd_ready_o, err_o});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_send();
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
        send_cmd(8'hEC, 8'd1);
        send_opnd(32'h1122_3344);
        tick();
        tick();
        n_checks++;
        if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL rst_send_byte2: got vld=%b data=%h, required 1/22",
                     tx_valid_o, tx_data_o);
        end
        tx_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tx_ready_i = 1'b1;
        n_checks++;
        if ({tx_valid_o, cmd_ready_o, busy_o, tx_data_o} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_send_state: got vld/cmd_rdy/busy=%b data=%h, required 010/00",
                     {tx_valid_o, cmd_ready_o, busy_o}, tx_data_o);
        end
        exp_tx.push_back(8'h09); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        send_cmd(8'hA0, 8'd1);
        send_opnd(32'd9);
        wait_idle("rst_send", 20);
        n_checks++;
        if (exp_tx.size() != 0 || exp_start.size() != 0) begin
            n_fail++;
            $display("FAIL rst_send_drain: got %0d tx/%0d starts left, required 0/0",
                     exp_tx.size(), exp_start.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops[255];
        logic [31:0] acc;
        alu_delay = 1;
        for (int i = 0; i < 255; i++) begin
            ops[i] = $urandom;
            if (i == 0) acc = ops[i];
            else begin
                exp_start.push_back({8'hA0, acc, ops[i]});
                acc = alu_model(8'hA0, acc, ops[i]);
            end
        end
        for (int i = 0; i < 4; i++) exp_tx.push_back(acc[i*8 +: 8]);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        send_cmd(8'hA0, 8'd255);
        for (int i = 0; i < 255; i++) send_opnd(ops[i]);
        n_checks++;
        if (op_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt255_stop: got op_ready_o=%b after 255 operands, required 0",
                     op_ready_o);
        end
        // Second command queued while the first is still transmitting.
        send_cmd(8'hEC, 8'd2);
        send_opnd(32'd1);
        send_opnd(32'd2);
        wait_idle("b2b", 30);
        n_checks++;
        if (exp_tx.size() != 0 || exp_start.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d tx/%0d starts left, required 0/0",
                     exp_tx.size(), exp_start.size());
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_opcode_i = 8'h00;
        cmd_count_i  = 8'h00;
        op_valid_i   = 1'b0;
        op_data_i    = 32'h0;
        tx_ready_i   = 1'b1;
        tick();
        test_reset();
        test_add();
        test_mul();
        test_echo_stall();
        test_bad_opcode();
        test_timeout();
        test_reset_mid_alu();
        test_reset_mid_send();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
